// File: rtl/pc_pkg.sv
// Shared types, defaults and helpers for the program-counter generator.
package pc_pkg;

  localparam int unsigned DEFAULT_XLEN = 32;
  localparam int unsigned DEFAULT_STEP = 4;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_state_e;

  // True when the low align_bits bits of addr are all zero (supports XLEN up to 64).
  function automatic logic is_aligned(input logic [63:0] addr, input int unsigned align_bits);
    logic [63:0] mask;
    mask = (64'd1 << align_bits) - 64'd1;
    return (addr & mask) == '0;
  endfunction

endpackage

// File: rtl/pc_incr.sv
// Combinational PC + STEP, modulo 2^XLEN.
module pc_incr #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned STEP = 4
) (
  input  logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_next
);

  // Sequential successor; carry out of the top bit is dropped.
  always_comb begin
    pc_next = pc + XLEN'(STEP);
  end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: holds the architectural PC, offers it to fetch
// over valid/ready, advances by STEP, takes redirects, halts on misalignment.
module pc_gen
  import pc_pkg::*;
#(
  parameter int unsigned          XLEN         = DEFAULT_XLEN,
  parameter logic [XLEN-1:0]      RESET_VECTOR = '0,
  parameter int unsigned          STEP         = DEFAULT_STEP,
  parameter int unsigned          ALIGN_BITS   = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_target_i,
  input  logic            fetch_ready_i,
  output logic            fetch_valid_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus_step_o,
  output logic            misalign_o,
  output logic            halted_o
);

  // Elaboration-time parameter sanity checks.
  if (!is_aligned(64'(RESET_VECTOR), ALIGN_BITS)) begin : g_bad_reset_vector
    $error("pc_gen: RESET_VECTOR is not aligned to ALIGN_BITS");
  end
  if (((STEP & (STEP - 1)) != 0) || (STEP < (32'd1 << ALIGN_BITS))) begin : g_bad_step
    $error("pc_gen: STEP must be a power of two and at least 2**ALIGN_BITS");
  end

  pc_state_e       state;
  pc_state_e       state_next;
  logic            fire;
  logic            target_aligned;
  logic [XLEN-1:0] pc_inc;

  pc_incr #(
    .XLEN (XLEN),
    .STEP (STEP)
  ) u_incr (
    .pc      (pc_o),
    .pc_next (pc_inc)
  );

  assign pc_plus_step_o = pc_inc;
  assign target_aligned = is_aligned(64'(redirect_target_i), ALIGN_BITS);
  assign fire           = fetch_valid_o & fetch_ready_i & ~stall_i;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= BOOT;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: BOOT lasts one cycle; a misaligned redirect in BOOT/RUN halts.
  always_comb begin
    state_next = state;
    case (state)
      BOOT:    state_next = RUN;
      RUN:     state_next = RUN;
      HALT:    state_next = HALT;
      default: state_next = HALT;
    endcase
    if ((state != HALT) && redirect_valid_i && !target_aligned) begin
      state_next = HALT;
    end
  end

  // State-decoded outputs.
  always_comb begin
    fetch_valid_o = 1'b0;
    halted_o      = 1'b0;
    case (state)
      RUN:     fetch_valid_o = 1'b1;
      HALT:    halted_o      = 1'b1;
      default: ;
    endcase
  end

  // PC and sticky fault: redirect beats fire; HALT freezes everything.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_o       <= RESET_VECTOR;
      misalign_o <= 1'b0;
    end else if (state != HALT) begin
      if (redirect_valid_i) begin
        pc_o <= redirect_target_i;
        if (!target_aligned) begin
          misalign_o <= 1'b1;
        end
      end else if (fire) begin
        pc_o <= pc_inc;
      end
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios then random traffic,
// compared against an arithmetic reference model of the PC rules.
module tb_pc_gen;

  localparam int unsigned XLEN = 32;
  localparam logic [31:0] RV   = 32'h0000_0000;
  localparam int unsigned STP  = 4;
  localparam int unsigned AB   = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall_i = 1'b0;
  logic        redirect_valid_i = 1'b0;
  logic [31:0] redirect_target_i = '0;
  logic        fetch_ready_i = 1'b0;
  logic        fetch_valid_o;
  logic [31:0] pc_o;
  logic [31:0] pc_plus_step_o;
  logic        misalign_o;
  logic        halted_o;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  // Reference model state.
  logic [31:0] m_pc    = RV;
  bit          m_valid = 1'b0;
  bit          m_halt  = 1'b0;
  bit          m_mis   = 1'b0;

  pc_gen #(
    .XLEN         (XLEN),
    .RESET_VECTOR (RV),
    .STEP         (STP),
    .ALIGN_BITS   (AB)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .stall_i           (stall_i),
    .redirect_valid_i  (redirect_valid_i),
    .redirect_target_i (redirect_target_i),
    .fetch_ready_i     (fetch_ready_i),
    .fetch_valid_o     (fetch_valid_o),
    .pc_o              (pc_o),
    .pc_plus_step_o    (pc_plus_step_o),
    .misalign_o        (misalign_o),
    .halted_o          (halted_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [31:0] exp_plus;
    exp_plus = 32'((64'(m_pc) + 64'(STP)) % 64'h1_0000_0000);
    chk({tag, ".pc"},       pc_o,                   m_pc);
    chk({tag, ".pc_plus"},  pc_plus_step_o,         exp_plus);
    chk({tag, ".valid"},    32'(fetch_valid_o),     32'(m_valid));
    chk({tag, ".misalign"}, 32'(misalign_o),        32'(m_mis));
    chk({tag, ".halted"},   32'(halted_o),          32'(m_halt));
  endtask

  // Advance one clock: model consumes the inputs present at the edge.
  task automatic tick(input string tag);
    if (!m_halt) begin
      if (redirect_valid_i) begin
        m_pc = redirect_target_i;
        if ((redirect_target_i % (32'd1 << AB)) != 0) begin
          m_halt = 1'b1;
          m_mis  = 1'b1;
        end
      end else if (m_valid && fetch_ready_i && !stall_i) begin
        m_pc = 32'((64'(m_pc) + 64'(STP)) % 64'h1_0000_0000);
      end
    end
    m_valid = !m_halt;
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  // Assert reset between edges, check it takes effect at once, then release
  // just after an edge so the following cycle is the single BOOT cycle.
  task automatic do_reset(input string tag);
    reset = 1'b1;
    m_pc = RV; m_valid = 1'b0; m_halt = 1'b0; m_mis = 1'b0;
    #1;
    check_all({tag, ".async"});
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check_all({tag, ".boot"});
  endtask

  task automatic set_in(input bit st, input bit rdy, input bit rv, input logic [31:0] tgt);
    stall_i = st; fetch_ready_i = rdy; redirect_valid_i = rv; redirect_target_i = tgt;
  endtask

  initial begin
    // Power-on reset and BOOT cycle.
    @(posedge clk);
    #1;
    check_all("por");
    reset = 1'b0;
    #1;
    check_all("boot");

    // Sequential stepping 0,4,8.
    set_in(0, 1, 0, '0);
    tick("run0");
    tick("run4");
    tick("run8");

    // Backpressure at 8: ready low, then stall high.
    set_in(0, 0, 0, '0);
    for (int i = 0; i < 3; i++) tick("noready");
    set_in(1, 1, 0, '0);
    for (int i = 0; i < 2; i++) tick("stall");
    set_in(0, 1, 0, '0);
    tick("release12");

    // Redirect under stall and no ready.
    set_in(1, 0, 1, 32'h100);
    tick("redir100");
    set_in(0, 1, 0, '0);
    tick("step104");

    // Redirect and fire together at pc=4.
    set_in(0, 1, 1, 32'h4);
    tick("redir4");
    set_in(0, 1, 1, 32'h40);
    tick("redir_beats_fire");

    // Misaligned redirect halts; later inputs ignored.
    set_in(0, 1, 1, 32'h102);
    tick("misalign");
    set_in(0, 1, 1, 32'h200);
    tick("halt_ign_redir");
    set_in(0, 1, 0, '0);
    tick("halt_ign_ready");
    do_reset("rst_after_halt");

    // Wrap-around and mid-run reset.
    set_in(0, 1, 0, '0);
    tick("boot_to_run");
    set_in(0, 1, 1, 32'hFFFF_FFFC);
    tick("preload_top");
    set_in(0, 1, 0, '0);
    tick("wrap0");
    tick("after_wrap");
    do_reset("rst_mid_run");

    // Random traffic, including misaligned targets, redirects in BOOT and resets.
    for (int i = 0; i < 600; i++) begin
      logic [31:0] tgt;
      tgt = $urandom & ~32'h3;
      if ($urandom_range(0, 15) == 0) tgt = tgt | 32'($urandom_range(1, 3));
      set_in($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
             $urandom_range(0, 7) == 0, tgt);
      if ((m_halt && $urandom_range(0, 3) == 0) || $urandom_range(0, 99) == 0) begin
        do_reset("rnd_reset");
      end else begin
        tick("rnd");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
